// File: rtl/jesd204b_pkg.sv
// Shared JESD204B link-layer definitions.
//   K28_3 / K28_7 : control octets used for /A/ (multiframe end) and /F/ (frame end)
//   octet_t       : one link octet
//   params_legal  : true when the F/N/K combination can be tracked by the
//                   character-replacement stage (F in {1,2,4,8}, F and N
//                   divide one another, 1 <= K <= 32)
package jesd204b_pkg;

    localparam logic [7:0] K28_3 = 8'h7C;
    localparam logic [7:0] K28_7 = 8'hFC;

    typedef logic [7:0] octet_t;

    function automatic bit params_legal(int f, int n, int k);
        bit f_ok;
        f_ok = (f == 1) || (f == 2) || (f == 4) || (f == 8);
        return f_ok && (n >= 1) && ((f % n == 0) || (n % f == 0)) &&
               (k >= 1) && (k <= 32);
    endfunction

endpackage

// File: rtl/jesd204b_char_replace_lane.sv
// Combinational replacement decision for a single octet.
// Ports:
//   oct_in        : original octet
//   eof / eomf    : octet sits at frame end / multiframe end
//   hist_vld      : prev_last holds a real octet (false for the first frame)
//   prev_last     : original last octet of the previous frame
//   prev_repl     : that octet was replaced
//   oct_out/k_out : octet to transmit and its K flag
//   *_nxt         : history seen by the next octet in transmit order
module jesd204b_char_replace_lane
    import jesd204b_pkg::*;
#(
    parameter bit SCR = 1'b0
) (
    input  logic [7:0] oct_in,
    input  logic       eof,
    input  logic       eomf,
    input  logic       hist_vld,
    input  logic [7:0] prev_last,
    input  logic       prev_repl,
    output logic [7:0] oct_out,
    output logic       k_out,
    output logic       hist_vld_nxt,
    output logic [7:0] prev_last_nxt,
    output logic       prev_repl_nxt
);

    always_comb begin
        oct_out       = oct_in;
        k_out         = 1'b0;
        hist_vld_nxt  = hist_vld;
        prev_last_nxt = prev_last;
        prev_repl_nxt = prev_repl;
        if (SCR) begin
            // Scrambled link: only octets that already equal the control
            // code are flagged; no history involved.
            if (eomf && oct_in == K28_3) begin
                k_out = 1'b1;
            end else if (eof && !eomf && oct_in == K28_7) begin
                k_out = 1'b1;
            end
        end else begin
            if (eomf && hist_vld && oct_in == prev_last) begin
                oct_out = K28_3;
                k_out   = 1'b1;
            end else if (eof && !eomf && hist_vld && !prev_repl &&
                         oct_in == prev_last) begin
                // No back-to-back /F/: a replaced predecessor blocks it.
                oct_out = K28_7;
                k_out   = 1'b1;
            end
            // History keeps the original octet, not the substituted code.
            if (eof) begin
                hist_vld_nxt  = 1'b1;
                prev_last_nxt = oct_in;
                prev_repl_nxt = k_out;
            end
        end
    end

endmodule

// File: rtl/jesd204b_tx_char_replace.sv
// JESD204B TX end-of-frame / end-of-multiframe character replacement.
// One output register stage; octet 0 (in_dat[7:0]) is transmitted first.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   realign           : restart frame/multiframe position at the next beat
//   in_val/in_rdy/in_dat    : upstream beat of N octets
//   out_val/out_rdy/out_dat : downstream beat after replacement
//   out_k             : per-octet K flag (bit i for octet i)
// Handshake: a beat moves when val & rdy are both high on a clock edge;
// out_dat/out_k stay frozen while out_val is high and out_rdy is low, and
// in_rdy = !rst & (!out_val | out_rdy) so the stage runs at full rate.
module jesd204b_tx_char_replace
    import jesd204b_pkg::*;
#(
    parameter int N   = 2,
    parameter int F   = 2,
    parameter int K   = 16,
    parameter bit SCR = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           realign,
    input  logic           in_val,
    output logic           in_rdy,
    input  logic [8*N-1:0] in_dat,
    output logic           out_val,
    input  logic           out_rdy,
    output logic [8*N-1:0] out_dat,
    output logic [N-1:0]   out_k
);

    localparam int OW = (F > 1) ? $clog2(F) : 1;
    localparam int FW = (K > 1) ? $clog2(K) : 1;

    if (!params_legal(F, N, K)) begin : g_bad_params
        $error("jesd204b_tx_char_replace: illegal F/N/K combination");
    end

    logic [OW-1:0] oct_pos;
    logic [FW-1:0] frm_pos;
    logic          hist_vld_q;
    logic [7:0]    prev_last_q;
    logic          prev_repl_q;

    logic          accept;
    logic [OW-1:0] oct_base;
    logic [OW-1:0] oct_nxt;

    // Per-octet chains: element i is the state seen by octet i of the beat,
    // element N is the state left for the next beat.
    logic [FW-1:0] frm_c [N+1];
    logic          hv_c  [N+1];
    logic [7:0]    pl_c  [N+1];
    logic          pr_c  [N+1];

    logic [N-1:0]   eof_v;
    logic [N-1:0]   eomf_v;
    logic [8*N-1:0] dat_rep;
    logic [N-1:0]   k_rep;

    assign in_rdy = !rst && (!out_val || out_rdy);
    assign accept = in_val && in_rdy;

    // A realign coincident with a beat makes that beat frame 0, octet 0.
    assign oct_base = realign ? '0   : oct_pos;
    assign frm_c[0] = realign ? '0   : frm_pos;
    assign hv_c[0]  = realign ? 1'b0 : hist_vld_q;
    assign pl_c[0]  = realign ? 8'h0 : prev_last_q;
    assign pr_c[0]  = realign ? 1'b0 : prev_repl_q;

    assign oct_nxt = OW'((int'(oct_base) + N) % F);

    for (genvar i = 0; i < N; i++) begin : g_lane
        assign eof_v[i]   = (((int'(oct_base) + i) % F) == F - 1);
        assign eomf_v[i]  = eof_v[i] && (frm_c[i] == FW'(K - 1));
        assign frm_c[i+1] = !eof_v[i]                  ? frm_c[i] :
                            (frm_c[i] == FW'(K - 1))   ? '0       :
                                                         frm_c[i] + FW'(1);

        jesd204b_char_replace_lane #(
            .SCR(SCR)
        ) u_lane (
            .oct_in       (in_dat[8*i +: 8]),
            .eof          (eof_v[i]),
            .eomf         (eomf_v[i]),
            .hist_vld     (hv_c[i]),
            .prev_last    (pl_c[i]),
            .prev_repl    (pr_c[i]),
            .oct_out      (dat_rep[8*i +: 8]),
            .k_out        (k_rep[i]),
            .hist_vld_nxt (hv_c[i+1]),
            .prev_last_nxt(pl_c[i+1]),
            .prev_repl_nxt(pr_c[i+1])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            oct_pos     <= '0;
            frm_pos     <= '0;
            hist_vld_q  <= 1'b0;
            prev_last_q <= 8'h0;
            prev_repl_q <= 1'b0;
            out_val     <= 1'b0;
            out_dat     <= '0;
            out_k       <= '0;
        end else begin
            if (accept) begin
                oct_pos     <= oct_nxt;
                frm_pos     <= frm_c[N];
                hist_vld_q  <= hv_c[N];
                prev_last_q <= pl_c[N];
                prev_repl_q <= pr_c[N];
                out_val     <= 1'b1;
                out_dat     <= dat_rep;
                out_k       <= k_rep;
            end else begin
                // Idle realign: forget position now so the next beat starts clean.
                if (realign) begin
                    oct_pos     <= '0;
                    frm_pos     <= '0;
                    hist_vld_q  <= 1'b0;
                    prev_last_q <= 8'h0;
                    prev_repl_q <= 1'b0;
                end
                if (out_rdy) begin
                    out_val <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_jesd204b_tx_char_replace.sv
// Bench for jesd204b_tx_char_replace. Three instances share every input:
//   0: F=2 K=4 SCR=0   1: F=2 K=4 SCR=1   2: F=1 K=16 SCR=0
// The reference model counts octets since the last realign/reset and derives
// frame position directly from that count.
module tb_jesd204b_tx_char_replace;

    localparam int N  = 2;
    localparam int NC = 3;

    logic          clk;
    logic          rst;
    logic          realign;
    logic          in_val;
    logic [15:0]   in_dat;
    logic          out_rdy;
    logic [NC-1:0] in_rdy_v;
    logic [NC-1:0] out_val_v;
    logic [15:0]   out_dat_a [NC];
    logic [1:0]    out_k_a   [NC];

    int checks   = 0;
    int failures = 0;

    // Scoreboard: one entry per beat held in the output stage, 18 bits per
    // instance laid out as {k[1:0], dat[15:0]}.
    logic [53:0] exp_q[$];

    int         m_cnt  [NC];
    logic [7:0] m_prev [NC];
    bit         m_repl [NC];
    bit         m_hv   [NC];

    jesd204b_tx_char_replace #(.N(2), .F(2), .K(4), .SCR(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .realign(realign), .in_val(in_val), .in_rdy(in_rdy_v[0]),
        .in_dat(in_dat), .out_val(out_val_v[0]), .out_rdy(out_rdy),
        .out_dat(out_dat_a[0]), .out_k(out_k_a[0]));

    jesd204b_tx_char_replace #(.N(2), .F(2), .K(4), .SCR(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .realign(realign), .in_val(in_val), .in_rdy(in_rdy_v[1]),
        .in_dat(in_dat), .out_val(out_val_v[1]), .out_rdy(out_rdy),
        .out_dat(out_dat_a[1]), .out_k(out_k_a[1]));

    jesd204b_tx_char_replace #(.N(2), .F(1), .K(16), .SCR(1'b0)) u_dut2 (
        .clk(clk), .rst(rst), .realign(realign), .in_val(in_val), .in_rdy(in_rdy_v[2]),
        .in_dat(in_dat), .out_val(out_val_v[2]), .out_rdy(out_rdy),
        .out_dat(out_dat_a[2]), .out_k(out_k_a[2]));

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int cfg_f(int c);
        return (c == 2) ? 1 : 2;
    endfunction

    function automatic int cfg_k(int c);
        return (c == 2) ? 16 : 4;
    endfunction

    function automatic bit cfg_s(int c);
        return (c == 1);
    endfunction

    function automatic void model_reset(int c);
        m_cnt[c]  = 0;
        m_prev[c] = 8'h00;
        m_repl[c] = 1'b0;
        m_hv[c]   = 1'b0;
    endfunction

    function automatic logic [17:0] model_beat(int c, logic [15:0] d);
        logic [15:0] od;
        logic [1:0]  ok;
        for (int i = 0; i < N; i++) begin
            logic [7:0] o;
            int         pos;
            int         frm;
            bit         eof;
            bit         eomf;
            bit         rep;
            o    = d[8*i +: 8];
            pos  = m_cnt[c] % cfg_f(c);
            frm  = (m_cnt[c] / cfg_f(c)) % cfg_k(c);
            eof  = (pos == cfg_f(c) - 1);
            eomf = eof && (frm == cfg_k(c) - 1);
            rep  = 1'b0;
            if (cfg_s(c)) begin
                rep = (eomf && o == 8'h7C) || (eof && !eomf && o == 8'hFC);
            end else begin
                if (eof && m_hv[c] && o == m_prev[c] && (eomf || !m_repl[c]))
                    rep = 1'b1;
                if (eof) begin
                    m_prev[c] = o;
                    m_repl[c] = rep;
                    m_hv[c]   = 1'b1;
                end
            end
            od[8*i +: 8] = rep ? (eomf ? 8'h7C : 8'hFC) : o;
            ok[i]        = rep;
            m_cnt[c]     = (m_cnt[c] + 1) % (cfg_f(c) * cfg_k(c));
        end
        return {ok, od};
    endfunction

    // ---------------- checking ----------------
    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver: one clock cycle, entered at a negedge ----------------
    task automatic cycle(bit r, bit v, logic [15:0] d, bit rl, bit ordy);
        bit          exp_val;
        bit          exp_rdy;
        bit          acc;
        bit          xfer;
        logic [53:0] front;
        logic [53:0] e;
        rst     = r;
        in_val  = v;
        in_dat  = d;
        realign = rl;
        out_rdy = ordy;
        #1;
        exp_val = (exp_q.size() != 0);
        exp_rdy = !r && (!exp_val || ordy);
        front   = exp_val ? exp_q[0] : 54'h0;
        for (int c = 0; c < NC; c++) begin
            check($sformatf("in_rdy%0d", c), 32'(in_rdy_v[c]), 32'(exp_rdy));
            check($sformatf("out_val%0d", c), 32'(out_val_v[c]), 32'(exp_val));
            if (exp_val) begin
                check($sformatf("out_dat%0d", c), 32'(out_dat_a[c]), 32'(front[18*c +: 16]));
                check($sformatf("out_k%0d", c), 32'(out_k_a[c]), 32'(front[18*c+16 +: 2]));
            end
        end
        acc  = v && exp_rdy;
        xfer = exp_val && ordy;
        if (r) begin
            exp_q.delete();
            for (int c = 0; c < NC; c++) model_reset(c);
        end else begin
            if (xfer) void'(exp_q.pop_front());
            if (rl) begin
                for (int c = 0; c < NC; c++) model_reset(c);
            end
            if (acc) begin
                for (int c = 0; c < NC; c++) e[18*c +: 18] = model_beat(c, d);
                exp_q.push_back(e);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect_out(int c, string tag, logic [15:0] dat, logic [1:0] k);
        check(tag, {14'h0, out_k_a[c], out_dat_a[c]}, {14'h0, k, dat});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst     = 1'b1;
        realign = 1'b0;
        in_val  = 1'b0;
        in_dat  = 16'h0;
        out_rdy = 1'b1;
        for (int c = 0; c < NC; c++) model_reset(c);
        @(negedge clk);

        // reset values
        cycle(1, 1, 16'hABCD, 0, 1);
        for (int c = 0; c < NC; c++) begin
            check($sformatf("rst_dat%0d", c), 32'(out_dat_a[c]), 32'h0);
            check($sformatf("rst_k%0d", c), 32'(out_k_a[c]), 32'h0);
        end

        // /F/ on matching frame end
        cycle(0, 1, 16'h2211, 1, 1);
        expect_out(0, "first_unchanged", 16'h2211, 2'b00);
        cycle(0, 1, 16'h2233, 0, 1);
        expect_out(0, "f_repl", 16'hFC33, 2'b10);
        cycle(0, 1, 16'h2255, 0, 1);
        expect_out(0, "no_consec_f", 16'h2255, 2'b00);
        cycle(0, 1, 16'h2266, 0, 1);
        expect_out(0, "a_repl", 16'h7C66, 2'b10);

        // only the middle of three matching frames gets /F/
        cycle(0, 1, 16'h2200, 1, 1);
        expect_out(0, "mid_f0", 16'h2200, 2'b00);
        cycle(0, 1, 16'h2201, 0, 1);
        expect_out(0, "mid_f1", 16'hFC01, 2'b10);
        cycle(0, 1, 16'h2202, 0, 1);
        expect_out(0, "mid_f2", 16'h2202, 2'b00);

        // scrambled rules
        cycle(0, 1, 16'hFC00, 1, 1);
        expect_out(1, "scr_f", 16'hFC00, 2'b10);
        cycle(0, 1, 16'h0000, 0, 1);
        expect_out(1, "scr_plain1", 16'h0000, 2'b00);
        cycle(0, 1, 16'h0000, 0, 1);
        expect_out(1, "scr_plain2", 16'h0000, 2'b00);
        cycle(0, 1, 16'h7C00, 0, 1);
        expect_out(1, "scr_a", 16'h7C00, 2'b10);

        // F=1: chained comparison inside one beat
        cycle(0, 1, 16'h3300, 1, 1);
        cycle(0, 1, 16'h3333, 0, 1);
        expect_out(2, "f1_chain", 16'h33FC, 2'b01);

        // backpressure: three stalled cycles, then resume
        cycle(0, 1, 16'h1234, 0, 1);
        cycle(0, 1, 16'h2234, 0, 0);
        cycle(0, 1, 16'h2234, 0, 0);
        cycle(0, 1, 16'h2234, 0, 0);
        check("stall_in_rdy", 32'(in_rdy_v), 32'h0);
        cycle(0, 1, 16'h2234, 0, 1);
        cycle(0, 0, 16'h0000, 0, 1);
        cycle(0, 0, 16'h0000, 0, 1);

        // idle realign at frame 2: next beat is frame 0, no comparison
        cycle(0, 1, 16'h5511, 1, 1);
        cycle(0, 1, 16'h5522, 0, 1);
        cycle(0, 0, 16'h0000, 1, 1);
        cycle(0, 1, 16'h5533, 0, 1);
        expect_out(0, "realign_f0", 16'h5533, 2'b00);
        cycle(0, 1, 16'h5544, 0, 1);
        expect_out(0, "realign_f1", 16'hFC44, 2'b10);

        // reset mid-multiframe while a beat is held
        cycle(0, 1, 16'h6601, 0, 1);
        cycle(0, 1, 16'h6602, 0, 0);
        cycle(1, 1, 16'h6603, 0, 0);
        check("rst_mid_val", 32'(out_val_v), 32'h0);
        check("rst_mid_dat", 32'(out_dat_a[0]), 32'h0);
        cycle(0, 1, 16'h6604, 0, 1);
        expect_out(0, "rst_mid_f0", 16'h6604, 2'b00);
        cycle(0, 1, 16'h6605, 0, 1);
        expect_out(0, "rst_mid_f1", 16'hFC05, 2'b10);

        // random val/rdy soak with a biased octet alphabet so matches occur
        for (int n = 0; n < 800; n++) begin
            logic [15:0] d;
            for (int i = 0; i < N; i++) begin
                case ($urandom_range(0, 4))
                    0:       d[8*i +: 8] = 8'h22;
                    1:       d[8*i +: 8] = 8'h7C;
                    2:       d[8*i +: 8] = 8'hFC;
                    3:       d[8*i +: 8] = 8'h00;
                    default: d[8*i +: 8] = 8'($urandom_range(0, 255));
                endcase
            end
            cycle($urandom_range(0, 150) == 0, $urandom_range(0, 3) != 0, d,
                  $urandom_range(0, 40) == 0, $urandom_range(0, 3) != 0);
        end
        cycle(0, 0, 16'h0000, 0, 1);
        cycle(0, 0, 16'h0000, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
